// File: rtl/ioc_bus_fabric.sv
// ioc_bus_fabric: CPU wishbone port to NSLOT IOC-space peripheral slots.
// Fixed-priority grant with registered per-slot strobes, IOC speed wait states,
// 8/16/32-bit lane extension, default data for unclaimed addresses and a bus timeout.
module ioc_bus_fabric #(
  parameter int NSLOT   = 4,
  parameter int DW      = 32,
  parameter int WS_SLOW = 15,
  parameter int WS_MED  = 7,
  parameter int WS_FAST = 3,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] DEF_DAT = {DW{1'b1}}
) (
  input  logic                clkcpu,
  input  logic                rst_i,
  input  logic                clk2m_en,
  input  logic                m_cyc,
  input  logic                m_stb,
  input  logic                m_we,
  input  logic [1:0]          m_speed,
  output logic [DW-1:0]       m_dat_o,
  output logic                m_ack,
  output logic                m_err,
  input  logic [NSLOT-1:0]    s_sel,
  input  logic [NSLOT-1:0]    s_w8,
  input  logic [NSLOT-1:0]    s_w16,
  input  logic [NSLOT*DW-1:0] s_dat,
  input  logic [NSLOT-1:0]    s_ack,
  output logic [NSLOT-1:0]    s_cyc,
  output logic [NSLOT-1:0]    s_stb,
  output logic                s_we
);

  localparam int GW  = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int WCW = 10;
  localparam int TCW = 11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SYNC, ST_DONE} state_t;

  // Lowest set index wins: slot 0 has the highest priority.
  function automatic logic [GW-1:0] prio_idx(input logic [NSLOT-1:0] sel);
    logic [GW-1:0] idx;
    idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (sel[i]) idx = GW'(i);
    end
    return idx;
  endfunction

  // Zero-extend narrow slots onto the full data bus; the 8-bit flag dominates.
  function automatic logic [DW-1:0] lane_ext(input logic [DW-1:0] d,
                                             input logic w8,
                                             input logic w16);
    logic [DW-1:0] r;
    r = d;
    if (w8) begin
      r = DW'(d[7:0]);
    end else if (w16) begin
      r = DW'(d[15:0]);
    end
    return r;
  endfunction

  // Wait-state count per IOC cycle type; sync cycles are paced by clk2m_en instead.
  function automatic logic [WCW-1:0] ws_load(input logic [1:0] spd);
    logic [WCW-1:0] w;
    case (spd)
      2'd0:    w = WCW'(WS_SLOW);
      2'd1:    w = WCW'(WS_MED);
      2'd2:    w = WCW'(WS_FAST);
      default: w = '0;
    endcase
    return w;
  endfunction

  state_t         state, state_nxt;
  logic [GW-1:0]  g_q;
  logic [1:0]     speed_q;
  logic           w8_q, w16_q;
  logic [WCW-1:0] wcnt;
  logic [TCW-1:0] tcnt;
  logic           ack_seen;

  logic           req;
  logic           any_sel;
  logic [GW-1:0]  sel_idx;
  logic           ack_now;
  logic           ack_ok;
  logic [TCW-1:0] tcnt_inc;
  logic           tmo_hit;
  logic [DW-1:0]  slot_dat;
  logic           go_grant, go_null, go_done, go_err, go_abort;

  assign req      = m_cyc & m_stb;
  assign any_sel  = |s_sel;
  assign sel_idx  = prio_idx(s_sel);
  assign ack_now  = s_ack[g_q];
  assign ack_ok   = (wcnt == '0) & (ack_seen | ack_now);
  assign tcnt_inc = tcnt + TCW'(1);
  assign tmo_hit  = (tcnt_inc >= TCW'(TIMEOUT));
  assign slot_dat = s_dat[g_q*DW +: DW];

  // Next-state and access-event decode; abort beats completion, completion beats timeout.
  always_comb begin
    state_nxt = state;
    go_grant  = 1'b0;
    go_null   = 1'b0;
    go_done   = 1'b0;
    go_err    = 1'b0;
    go_abort  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (any_sel) begin
            go_grant  = 1'b1;
            state_nxt = ST_WAIT;
          end else begin
            go_null   = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (!m_cyc) begin
          go_abort  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (ack_ok) begin
          if (speed_q == 2'd3) begin
            state_nxt = ST_SYNC;
          end else begin
            go_done   = 1'b1;
            state_nxt = ST_DONE;
          end
        end else if (tmo_hit) begin
          go_err    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_SYNC: begin
        if (!m_cyc) begin
          go_abort  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (clk2m_en) begin
          go_done   = 1'b1;
          state_nxt = ST_DONE;
        end else if (tmo_hit) begin
          go_err    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!m_stb) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant latch: slot index, cycle type and lane width held for the whole access.
  always_ff @(posedge clkcpu) begin
    if (go_grant) begin
      g_q     <= sel_idx;
      speed_q <= m_speed;
      w8_q    <= s_w8[sel_idx];
      w16_q   <= s_w16[sel_idx];
    end
  end

  // Slot strobes, wait-state/timeout counters and the sticky slot ack.
  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      s_cyc    <= '0;
      s_stb    <= '0;
      s_we     <= 1'b0;
      wcnt     <= '0;
      tcnt     <= '0;
      ack_seen <= 1'b0;
    end else begin
      if (go_grant) begin
        s_cyc    <= NSLOT'(1) << sel_idx;
        s_stb    <= NSLOT'(1) << sel_idx;
        s_we     <= m_we;
        wcnt     <= ws_load(m_speed);
        tcnt     <= '0;
        ack_seen <= 1'b0;
      end else begin
        if (go_done || go_err || go_abort) begin
          s_cyc <= '0;
          s_stb <= '0;
          s_we  <= 1'b0;
        end
        if (state == ST_WAIT) begin
          wcnt     <= (wcnt == '0) ? '0 : wcnt - WCW'(1);
          ack_seen <= ack_seen | ack_now;
        end
        if (state == ST_WAIT || state == ST_SYNC) begin
          tcnt <= tcnt_inc;
        end
      end
    end
  end

  // Master response: one-cycle ack/err pulses and the registered read data.
  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_dat_o <= '0;
    end else begin
      m_ack <= go_done | go_null;
      m_err <= go_err;
      if (go_null || go_err) begin
        m_dat_o <= DEF_DAT;
      end else if (go_done && !s_we) begin
        m_dat_o <= lane_ext(slot_dat, w8_q, w16_q);
      end
    end
  end

endmodule

// File: tb/tb_ioc_bus_fabric.sv
// Testbench for ioc_bus_fabric: directed scenarios plus randomized accesses
// compared against a cycle-count reference model of the access rules.
module tb_ioc_bus_fabric;

  localparam int NSLOT   = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 255;
  localparam logic [DW-1:0] DEF = 32'hFFFF_FFFF;
  localparam int MAXK    = 600;

  logic                clkcpu = 1'b0;
  logic                rst_i, clk2m_en, m_cyc, m_stb, m_we;
  logic [1:0]          m_speed;
  logic [DW-1:0]       m_dat_o;
  logic                m_ack, m_err;
  logic [NSLOT-1:0]    s_sel, s_w8, s_w16, s_ack, s_cyc, s_stb;
  logic [NSLOT*DW-1:0] s_dat;
  logic                s_we;

  always #5 clkcpu = ~clkcpu;

  ioc_bus_fabric #(
    .NSLOT(NSLOT), .DW(DW), .WS_SLOW(15), .WS_MED(7), .WS_FAST(3),
    .TIMEOUT(TIMEOUT), .DEF_DAT(DEF)
  ) dut (
    .clkcpu(clkcpu), .rst_i(rst_i), .clk2m_en(clk2m_en),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_speed(m_speed),
    .m_dat_o(m_dat_o), .m_ack(m_ack), .m_err(m_err),
    .s_sel(s_sel), .s_w8(s_w8), .s_w16(s_w16), .s_dat(s_dat), .s_ack(s_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we)
  );

  int checks = 0;
  int errors = 0;

  // access description
  logic [NSLOT-1:0] a_sel, a_w8, a_w16;
  logic [1:0]       a_speed;
  logic             a_we;
  logic [DW-1:0]    a_dat [NSLOT];
  bit               ack_pat [MAXK];
  bit               en_pat  [MAXK];
  int               abort_k, rst_k;
  bit               resel;

  // observations
  int               o_ack_k, o_err_k, o_ack_cnt, o_err_cnt;
  logic [DW-1:0]    o_dat, o_dat_end;
  logic [NSLOT-1:0] o_stb_or, o_stb_end;
  bit               o_multi, o_both, o_we_bad;

  // model results
  int               e_ack_k, e_err_k;
  logic [DW-1:0]    e_dat;
  logic [NSLOT-1:0] e_stb;
  logic [DW-1:0]    hold_dat;

  task automatic idle_bus();
    m_cyc = 0; m_stb = 0; m_we = 0; m_speed = 0;
    s_sel = 0; s_ack = 0; clk2m_en = 0;
  endtask

  task automatic clear_pats();
    for (int i = 0; i < MAXK; i++) begin
      ack_pat[i] = 0;
      en_pat[i]  = 0;
    end
    abort_k = 0; rst_k = 0; resel = 0;
    a_w8 = 0; a_w16 = 0; a_we = 0;
    for (int i = 0; i < NSLOT; i++) a_dat[i] = $urandom;
  endtask

  // Runs one access starting #1 after a rising edge; k counts cycles after the request.
  task automatic do_access();
    int stop_k;
    s_w8 = a_w8; s_w16 = a_w16;
    for (int i = 0; i < NSLOT; i++) s_dat[i*DW +: DW] = a_dat[i];
    m_cyc = 1; m_stb = 1; m_we = a_we; m_speed = a_speed; s_sel = a_sel;
    s_ack = ack_pat[0] ? '1 : '0;
    clk2m_en = en_pat[0];
    o_ack_k = -1; o_err_k = -1; o_ack_cnt = 0; o_err_cnt = 0;
    o_dat = 'x; o_stb_or = 0; o_multi = 0; o_both = 0; o_we_bad = 0;
    stop_k = -1;
    for (int k = 1; k < MAXK; k++) begin
      @(posedge clkcpu); #1;
      if (m_ack) begin o_ack_cnt++; if (o_ack_k < 0) o_ack_k = k; o_dat = m_dat_o; end
      if (m_err) begin o_err_cnt++; if (o_err_k < 0) o_err_k = k; o_dat = m_dat_o; end
      if (m_ack && m_err) o_both = 1;
      if ($countones(s_stb) > 1) o_multi = 1;
      if (s_stb != 0 && s_we !== a_we) o_we_bad = 1;
      o_stb_or  = o_stb_or | s_stb;
      o_stb_end = s_stb;
      o_dat_end = m_dat_o;
      rst_i    = 0;
      s_ack    = ack_pat[k] ? '1 : '0;
      clk2m_en = en_pat[k];
      if (resel && k == 1) s_sel = NSLOT'($urandom);
      if (stop_k < 0 && (o_ack_k >= 0 || o_err_k >= 0)) begin
        m_cyc = 0; m_stb = 0; s_sel = 0; stop_k = k;
      end
      if (k == abort_k) begin m_cyc = 0; m_stb = 0; stop_k = k; end
      if (k == rst_k) begin rst_i = 1; m_cyc = 0; m_stb = 0; stop_k = k; end
      if (stop_k >= 0 && k >= stop_k + 3) break;
    end
    idle_bus();
    rst_i = 0;
  endtask

  function automatic logic [DW-1:0] extend(input logic [DW-1:0] d, input logic w8, input logic w16);
    if (w8) return d & 32'h0000_00FF;
    if (w16) return d & 32'h0000_FFFF;
    return d;
  endfunction

  // Reference: ack lands one cycle after the first cycle where the wait budget is spent
  // and an ack has been seen (plus the first clk2m_en for sync cycles); else timeout.
  task automatic model();
    int g, w, fa, cw, c;
    e_err_k = -1; e_ack_k = -1;
    if (a_sel == 0) begin
      e_ack_k = 1; e_dat = DEF; e_stb = 0;
      return;
    end
    g = 0;
    for (int i = 0; i < NSLOT; i++) if (a_sel[i]) begin g = i; break; end
    e_stb = 0; e_stb[g] = 1'b1;
    w = (a_speed == 0) ? 15 : (a_speed == 1) ? 7 : (a_speed == 2) ? 3 : 0;
    fa = -1;
    for (int j = 1; j < MAXK; j++) if (ack_pat[j]) begin fa = j; break; end
    cw = (fa < 0) ? 100000 : ((w + 1 > fa) ? w + 1 : fa);
    c = cw;
    if (a_speed == 3 && fa >= 0) begin
      c = 100000;
      for (int j = cw + 1; j < MAXK; j++) if (en_pat[j]) begin c = j; break; end
    end
    if (c <= TIMEOUT) begin
      e_ack_k = c + 1;
      e_dat = a_we ? hold_dat : extend(a_dat[g], a_w8[g], a_w16[g]);
    end else begin
      e_err_k = TIMEOUT + 1;
      e_dat = DEF;
    end
  endtask

  task automatic test_reset();
    idle_bus(); rst_i = 1;
    s_w8 = 0; s_w16 = 0; s_dat = 0;
    repeat (3) @(posedge clkcpu);
    #1;
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL reset_m_ack: got %b expected 0", m_ack); end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_m_err: got %b expected 0", m_err); end
    checks++; if (m_dat_o !== '0) begin errors++; $display("FAIL reset_m_dat_o: got %h expected 0", m_dat_o); end
    checks++; if (s_cyc !== '0 || s_stb !== '0) begin errors++; $display("FAIL reset_s_cyc_stb: got %b/%b expected 0/0", s_cyc, s_stb); end
    checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL reset_s_we: got %b expected 0", s_we); end
    rst_i = 0; hold_dat = 0;
    @(posedge clkcpu); #1;
  endtask

  task automatic test_width8();
    clear_pats();
    a_sel = 4'b0110; a_speed = 2; a_w8 = 4'b0010; a_dat[1] = 32'hAABBCC5A;
    for (int k = 0; k < MAXK; k++) ack_pat[k] = 1;
    do_access();
    checks++; if (o_ack_k != 5) begin errors++; $display("FAIL w8_ack_cycle: got %0d expected 5", o_ack_k); end
    checks++; if (o_dat !== 32'h0000005A) begin errors++; $display("FAIL w8_data: got %h expected 0000005a", o_dat); end
    checks++; if (o_stb_or !== 4'b0010) begin errors++; $display("FAIL w8_grant: got %b expected 0010", o_stb_or); end
    checks++; if (o_ack_cnt != 1 || o_err_cnt != 0) begin errors++; $display("FAIL w8_pulses: got ack %0d err %0d expected 1/0", o_ack_cnt, o_err_cnt); end
    hold_dat = 32'h0000005A;
  endtask

  task automatic test_null();
    clear_pats();
    a_sel = 0; a_speed = 1;
    do_access();
    checks++; if (o_ack_k != 1) begin errors++; $display("FAIL null_ack_cycle: got %0d expected 1", o_ack_k); end
    checks++; if (o_dat !== DEF) begin errors++; $display("FAIL null_data: got %h expected %h", o_dat, DEF); end
    checks++; if (o_stb_or !== 0) begin errors++; $display("FAIL null_no_stb: got %b expected 0000", o_stb_or); end
    checks++; if (o_ack_cnt != 1) begin errors++; $display("FAIL null_ack_count: got %0d expected 1", o_ack_cnt); end
    hold_dat = DEF;
  endtask

  task automatic test_timeout();
    clear_pats();
    a_sel = 4'b0001; a_speed = 2;
    do_access();
    checks++; if (o_err_k != 256) begin errors++; $display("FAIL tmo_err_cycle: got %0d expected 256", o_err_k); end
    checks++; if (o_err_cnt != 1 || o_ack_cnt != 0) begin errors++; $display("FAIL tmo_pulses: got err %0d ack %0d expected 1/0", o_err_cnt, o_ack_cnt); end
    checks++; if (o_dat !== DEF) begin errors++; $display("FAIL tmo_data: got %h expected %h", o_dat, DEF); end
    hold_dat = DEF;
  endtask

  task automatic test_sync();
    int phases [3] = '{0, 1, 7};
    int first, exp_k;
    foreach (phases[p]) begin
      clear_pats();
      a_sel = 4'b1000; a_speed = 3; a_dat[3] = 32'h1234_5678 + p;
      for (int k = 0; k < MAXK; k++) begin
        ack_pat[k] = 1;
        en_pat[k]  = (k % 16 == phases[p]);
      end
      do_access();
      first = (phases[p] >= 2) ? phases[p] : phases[p] + 16;
      exp_k = first + 1;
      checks++; if (o_ack_k != exp_k) begin errors++; $display("FAIL sync_ack_cycle_phase%0d: got %0d expected %0d", phases[p], o_ack_k, exp_k); end
      checks++; if (o_dat !== a_dat[3]) begin errors++; $display("FAIL sync_data_phase%0d: got %h expected %h", phases[p], o_dat, a_dat[3]); end
      hold_dat = a_dat[3];
    end
  endtask

  task automatic test_early_ack();
    clear_pats();
    a_sel = 4'b0100; a_speed = 0; a_w16 = 4'b0100; a_dat[2] = 32'hDEAD_BEEF;
    ack_pat[11] = 1;
    do_access();
    checks++; if (o_ack_k != 17) begin errors++; $display("FAIL early_ack_cycle: got %0d expected 17", o_ack_k); end
    checks++; if (o_err_cnt != 0) begin errors++; $display("FAIL early_ack_err: got %0d expected 0", o_err_cnt); end
    checks++; if (o_dat !== 32'h0000BEEF) begin errors++; $display("FAIL early_ack_data: got %h expected 0000beef", o_dat); end
    hold_dat = 32'h0000BEEF;
  endtask

  task automatic test_abort_reset();
    for (int run = 0; run < 2; run++) begin
      clear_pats();
      a_sel = 4'b0100; a_speed = 0;
      for (int k = 0; k < MAXK; k++) ack_pat[k] = 1;
      if (run == 0) abort_k = 3; else rst_k = 3;
      do_access();
      if (run == 1) hold_dat = 0;
      checks++; if (o_stb_or !== 4'b0100) begin errors++; $display("FAIL abort%0d_granted: got %b expected 0100", run, o_stb_or); end
      checks++; if (o_stb_end !== 0) begin errors++; $display("FAIL abort%0d_stb_cleared: got %b expected 0000", run, o_stb_end); end
      checks++; if (o_ack_cnt != 0 || o_err_cnt != 0) begin errors++; $display("FAIL abort%0d_no_pulse: got ack %0d err %0d expected 0/0", run, o_ack_cnt, o_err_cnt); end
      checks++; if (o_dat_end !== hold_dat) begin errors++; $display("FAIL abort%0d_data: got %h expected %h", run, o_dat_end, hold_dat); end
      clear_pats();
      a_sel = 4'b0010; a_speed = 2; a_dat[1] = 32'hC0DE_0000 + run;
      for (int k = 0; k < MAXK; k++) ack_pat[k] = 1;
      do_access();
      checks++; if (o_ack_k != 5) begin errors++; $display("FAIL abort%0d_fresh_ack: got %0d expected 5", run, o_ack_k); end
      checks++; if (o_dat !== a_dat[1]) begin errors++; $display("FAIL abort%0d_fresh_data: got %h expected %h", run, o_dat, a_dat[1]); end
      hold_dat = a_dat[1];
    end
  endtask

  task automatic test_random();
    int fa, ph;
    for (int it = 0; it < 40; it++) begin
      clear_pats();
      a_sel   = ($urandom % 8 == 0) ? '0 : NSLOT'($urandom_range(1, 15));
      a_speed = 2'($urandom % 4);
      a_we    = ($urandom % 4 == 0);
      a_w8    = NSLOT'($urandom);
      a_w16   = NSLOT'($urandom);
      resel   = $urandom % 2;
      if ($urandom % 12 != 0) begin
        fa = $urandom_range(1, 30);
        ack_pat[fa] = 1;
        for (int k = fa + 1; k < MAXK; k++) ack_pat[k] = ($urandom % 3 == 0);
      end
      ph = $urandom % 16;
      for (int k = 0; k < MAXK; k++) en_pat[k] = (k % 16 == ph) || ($urandom % 8 == 0);
      model();
      do_access();
      checks++; if (o_ack_k != e_ack_k) begin errors++; $display("FAIL rnd%0d_ack_cycle: got %0d expected %0d", it, o_ack_k, e_ack_k); end
      checks++; if (o_err_k != e_err_k) begin errors++; $display("FAIL rnd%0d_err_cycle: got %0d expected %0d", it, o_err_k, e_err_k); end
      checks++; if (o_dat !== e_dat) begin errors++; $display("FAIL rnd%0d_data: got %h expected %h", it, o_dat, e_dat); end
      checks++; if (o_stb_or !== e_stb) begin errors++; $display("FAIL rnd%0d_grant: got %b expected %b", it, o_stb_or, e_stb); end
      checks++; if (o_ack_cnt + o_err_cnt != 1) begin errors++; $display("FAIL rnd%0d_pulse_count: got %0d expected 1", it, o_ack_cnt + o_err_cnt); end
      checks++; if (o_multi || o_both || o_we_bad) begin errors++; $display("FAIL rnd%0d_invariants: got multi %0d both %0d we_bad %0d expected 0/0/0", it, o_multi, o_both, o_we_bad); end
      hold_dat = e_dat;
    end
  endtask

  initial begin
    test_reset();
    test_width8();
    test_null();
    test_timeout();
    test_sync();
    test_early_ack();
    test_abort_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
